// File: rtl/onehot_mult_ctrl.sv
// One-hot sequencer for the serial shift-add multiplier: turns start/lsb into load, clear, add and shift strobes.
// Latency: done rises 2N+2 cycles after start is sampled in IDLE; strobes are combinational from the state flops.
// Backpressure: none downstream; done holds until start is seen low, and start is ignored outside IDLE/DONE.
// Optional build macro ONEHOT_CHECK_EN adds the illegal-state check, recovery to IDLE and the sticky err flag.
module onehot_mult_ctrl #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lsb,
  output logic       ld_a,
  output logic       ld_b,
  output logic       clr_p,
  output logic       add_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic [4:0] state,
  output logic       err
);

  // Bit positions of each state inside the one-hot vector.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_bit_e;

  logic [4:0]    state_q;
  logic [4:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_iter;

`ifdef ONEHOT_CHECK_EN
  logic illegal;
  logic err_q;
`endif

  // State and iteration counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 5'b00001;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state terms per state bit, counter update and output strobes.
  always_comb begin
    state_d   = '0;
    cnt_d     = cnt_q;
    last_iter = (cnt_q == CW'(N - 1));

    // Each bit is the OR of the transitions that enter it.
    state_d[S_IDLE]  = (state_q[S_IDLE] & ~start) | (state_q[S_DONE] & ~start);
    state_d[S_INIT]  = state_q[S_IDLE] & start;
    state_d[S_ADD]   = state_q[S_INIT] | (state_q[S_SHIFT] & ~last_iter);
    state_d[S_SHIFT] = state_q[S_ADD];
    state_d[S_DONE]  = (state_q[S_SHIFT] & last_iter) | (state_q[S_DONE] & start);

    // Counter restarts in INIT; it holds at N-1 on the final shift so it never
    // leaves the 0..N-1 range and only wraps back through INIT.
    if (state_q[S_INIT]) begin
      cnt_d = '0;
    end
    if (state_q[S_SHIFT] && !last_iter) begin
      cnt_d = cnt_q + 1'b1;
    end

`ifdef ONEHOT_CHECK_EN
    // Zero or multiple bits set: abandon the operation and return to IDLE.
    illegal = (state_q == 5'b00000) || ((state_q & (state_q - 5'd1)) != 5'b00000);
    if (illegal) begin
      state_d = 5'b00001;
      cnt_d   = '0;
    end
`endif

    ld_a     = state_q[S_INIT];
    ld_b     = state_q[S_INIT];
    clr_p    = state_q[S_INIT];
    add_en   = state_q[S_ADD] & lsb;
    shift_en = state_q[S_SHIFT];
    done     = state_q[S_DONE];
    busy     = ~state_q[S_IDLE];
  end

`ifdef ONEHOT_CHECK_EN
  // Sticky illegal-state flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign state = state_q;

endmodule
